// File: rtl/echo_detector_if.sv
// Echo detector bus: burst start, TUSS comparator
// inputs and the TOF / presence results.
interface echo_detector_if #(
  parameter int TOF_W = 16
);
  logic             detect_en;
  logic             out_3;
  logic             out_4;
  logic             busy;
  logic             tof_valid;
  logic [TOF_W-1:0] tof;
  logic             miss;
  logic             detected;

  modport master (
    output detect_en,
    output out_3,
    output out_4,
    input  busy,
    input  tof_valid,
    input  tof,
    input  miss,
    input  detected
  );

  modport slave (
    input  detect_en,
    input  out_3,
    input  out_4,
    output busy,
    output tof_valid,
    output tof,
    output miss,
    output detected
  );
endinterface

// File: rtl/echo_detector.sv
// Echo qualification: blanking, debounced TOF capture
// and multi-burst confirmation of object presence.
module echo_detector #(
  parameter int BLANK_CYC  = 2000,
  parameter int WINDOW_CYC = 60000,
  parameter int DEB_CYC    = 8,
  parameter int CONFIRM_N  = 3,
  parameter int TOF_W      = 16
) (
  input logic             gclk,
  input logic             rstn,
  echo_detector_if.slave  bus
);

  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int CW = $clog2(CONFIRM_N + 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    LISTEN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [1:0]       sync3, sync4;
  logic             s3, s4;
  logic [BW-1:0]    blank_cnt, blank_n;
  logic [TOF_W-1:0] win_cnt, win_n;
  logic [DW-1:0]    deb_cnt, deb_n;
  logic             seen3, seen_n;
  logic [TOF_W-1:0] run_start, start_n;
  logic             armed, armed_n;
  logic [TOF_W-1:0] tof_r, tof_n;
  logic             hit_r, hit_n;
  logic [CW-1:0]    hit_cnt, cnt_n;
  logic             det_r, det_n;

  logic             run_seen;
  logic [DW-1:0]    deb_inc;
  logic [TOF_W-1:0] start_c;
  logic             good;

  assign s3 = sync3[1];
  assign s4 = sync4[1];

  always_ff @(posedge gclk) begin
    if (rstn) begin
      sync3     <= '0;
      sync4     <= '0;
      state     <= IDLE;
      blank_cnt <= '0;
      win_cnt   <= '0;
      deb_cnt   <= '0;
      seen3     <= 1'b0;
      run_start <= '0;
      armed     <= 1'b0;
      tof_r     <= '0;
      hit_r     <= 1'b0;
      hit_cnt   <= '0;
      det_r     <= 1'b0;
    end else begin
      sync3     <= {sync3[0], bus.out_3};
      sync4     <= {sync4[0], bus.out_4};
      state     <= state_n;
      blank_cnt <= blank_n;
      win_cnt   <= win_n;
      deb_cnt   <= deb_n;
      seen3     <= seen_n;
      run_start <= start_n;
      armed     <= armed_n;
      tof_r     <= tof_n;
      hit_r     <= hit_n;
      hit_cnt   <= cnt_n;
      det_r     <= det_n;
    end
  end

  always_comb begin
    state_n  = state;
    blank_n  = blank_cnt;
    win_n    = win_cnt;
    deb_n    = deb_cnt;
    seen_n   = seen3;
    start_n  = run_start;
    armed_n  = armed;
    tof_n    = tof_r;
    hit_n    = hit_r;
    cnt_n    = hit_cnt;
    det_n    = det_r;
    good     = 1'b0;
    run_seen = (deb_cnt == '0) ? s3 : (seen3 | s3);
    deb_inc  = deb_cnt + DW'(1);
    start_c  = (deb_cnt == '0) ? win_cnt : run_start;
    unique case (state)
      IDLE: begin
        if (bus.detect_en) begin
          state_n = BLANK;
          blank_n = '0;
        end
      end
      BLANK: begin
        if (blank_cnt == BW'(BLANK_CYC - 1)) begin
          state_n = LISTEN;
          win_n   = '0;
          deb_n   = '0;
          seen_n  = 1'b0;
          armed_n = 1'b1;
        end else begin
          blank_n = blank_cnt + BW'(1);
        end
      end
      LISTEN: begin
        win_n = win_cnt + TOF_W'(1);
        if (!s4) begin
          deb_n   = '0;
          seen_n  = 1'b0;
          armed_n = 1'b1;
        end else if (armed) begin
          if (deb_inc == DW'(DEB_CYC)) begin
            deb_n  = '0;
            seen_n = 1'b0;
            if (run_seen) begin
              good  = 1'b1;
              tof_n = start_c;
            end else begin
              // noise run: wait for s4 low before re-arming
              armed_n = 1'b0;
            end
          end else begin
            deb_n   = deb_inc;
            seen_n  = run_seen;
            start_n = start_c;
          end
        end
        if (good || win_cnt == TOF_W'(WINDOW_CYC - 1)) begin
          state_n = DONE;
          hit_n   = good;
          if (good) begin
            if (hit_cnt != CW'(CONFIRM_N))
              cnt_n = hit_cnt + CW'(1);
            det_n = (cnt_n == CW'(CONFIRM_N));
          end else begin
            cnt_n = '0;
            det_n = 1'b0;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.tof_valid = (state == DONE) && hit_r;
  assign bus.miss      = (state == DONE) && !hit_r;
  assign bus.tof       = tof_r;
  assign bus.detected  = det_r;

endmodule

// File: tb/tb_echo_detector.sv
// Directed bench for echo_detector with small
// parameters; cycle offsets are relative to detect_en.
module tb_echo_detector;

  logic gclk = 1'b0;
  logic rstn = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 gclk = ~gclk;

  echo_detector_if #(.TOF_W(16)) bus ();

  echo_detector #(
    .BLANK_CYC (10),
    .WINDOW_CYC(100),
    .DEB_CYC   (4),
    .CONFIRM_N (3),
    .TOF_W     (16)
  ) dut (
    .gclk(gclk),
    .rstn(rstn),
    .bus (bus)
  );

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  int tv_cyc, tv_n, tof_at, miss_cyc, miss_n;
  int det_done, det_pre, busy_low;

  task automatic burst(input int a4, input int l4,
                       input int b4, input int m4,
                       input int a3, input int l3,
                       input int re);
    int prev_det;
    tv_cyc = -1; tv_n = 0; tof_at = -1;
    miss_cyc = -1; miss_n = 0;
    det_done = -1; det_pre = -1; busy_low = -1;
    prev_det = int'(bus.detected);
    for (int k = 0; k < 125; k++) begin
      bus.detect_en = (k == 0 || k == re);
      bus.out_4 = (k >= a4 && k < a4 + l4) ||
                  (k >= b4 && k < b4 + m4);
      bus.out_3 = (k >= a3 && k < a3 + l3);
      if (bus.tof_valid) begin
        if (tv_n == 0) begin
          tv_cyc   = k;
          tof_at   = int'(bus.tof);
          det_done = int'(bus.detected);
          det_pre  = prev_det;
        end
        tv_n++;
      end
      if (bus.miss) begin
        if (miss_n == 0) begin
          miss_cyc = k;
          det_done = int'(bus.detected);
          det_pre  = prev_det;
        end
        miss_n++;
      end
      if (k > 0 && !bus.busy && busy_low < 0)
        busy_low = k;
      prev_det = int'(bus.detected);
      step();
    end
    bus.detect_en = 1'b0;
    bus.out_4 = 1'b0;
    bus.out_3 = 1'b0;
  endtask

  task automatic hit22(input string tag, input int det);
    burst(31, 10, -1, 0, 31, 10, -1);
    check({tag, "_tv"}, tv_cyc, 37);
    check({tag, "_tof"}, tof_at, 22);
    check({tag, "_det"}, det_done, det);
  endtask

  initial begin
    bus.detect_en = 1'b0;
    bus.out_3 = 1'b0;
    bus.out_4 = 1'b0;
    repeat (3) step();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_tv", int'(bus.tof_valid), 0);
    check("rst_miss", int'(bus.miss), 0);
    check("rst_det", int'(bus.detected), 0);
    check("rst_tof", int'(bus.tof), 0);
    rstn = 1'b0;
    step();

    burst(31, 10, -1, 0, 31, 10, -1);
    check("t1_tv_cyc", tv_cyc, 37);
    check("t1_tv_n", tv_n, 1);
    check("t1_tof", tof_at, 22);
    check("t1_miss_n", miss_n, 0);
    check("t1_det", det_done, 0);
    check("t1_busy_low", busy_low, 38);
    check("t1_tof_hold", int'(bus.tof), 22);

    burst(20, 3, 40, 6, -1, 0, -1);
    check("t2_tv_n", tv_n, 0);
    check("t2_miss_cyc", miss_cyc, 111);
    check("t2_miss_n", miss_n, 1);
    check("t2_busy_low", busy_low, 112);
    check("t2_tof_hold", int'(bus.tof), 22);

    hit22("t3_b1", 0);
    hit22("t3_b2", 0);
    hit22("t3_b3", 1);
    check("t3_b3_pre", det_pre, 0);
    burst(-1, 0, -1, 0, -1, 0, -1);
    check("t3_b4_miss", miss_cyc, 111);
    check("t3_b4_pre", det_pre, 1);
    check("t3_b4_det", det_done, 0);

    burst(5, 20, -1, 0, 5, 20, -1);
    check("t4a_tv_cyc", tv_cyc, 15);
    check("t4a_tof", tof_at, 0);
    burst(105, 10, -1, 0, 105, 10, -1);
    check("t4b_tv_cyc", tv_cyc, 111);
    check("t4b_tof", tof_at, 96);
    check("t4b_miss_n", miss_n, 0);
    burst(107, 10, -1, 0, 107, 10, -1);
    check("t4c_tv_n", tv_n, 0);
    check("t4c_miss_cyc", miss_cyc, 111);
    check("t4c_tof_hold", int'(bus.tof), 96);

    burst(31, 10, -1, 0, 31, 10, 20);
    check("t5_re_tv_n", tv_n, 1);
    check("t5_re_tof", tof_at, 22);
    check("t5_re_cyc", tv_cyc, 37);
    hit22("t5_h2", 0);

    bus.detect_en = 1'b1;
    step();
    bus.detect_en = 1'b0;
    repeat (30) step();
    check("t5_pre_busy", int'(bus.busy), 1);
    rstn = 1'b1;
    step();
    rstn = 1'b0;
    check("t5_r_busy", int'(bus.busy), 0);
    check("t5_r_tv", int'(bus.tof_valid), 0);
    check("t5_r_miss", int'(bus.miss), 0);
    check("t5_r_det", int'(bus.detected), 0);
    check("t5_r_tof", int'(bus.tof), 0);
    step();
    check("t5_r_idle", int'(bus.busy), 0);
    hit22("t5_p1", 0);
    hit22("t5_p2", 0);
    hit22("t5_p3", 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
